serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
- Parametrised, multi-cycle adder/subtractor for the datapath; successor to the single-cycle 16-bit address adder.
- Processes a WIDTH-bit operation as WIDTH/CHUNK slices, least-significant slice first, one slice per clock, with a ripple carry held between slices.
- Start/busy/done handshake; registered result plus carry, overflow and zero flags.
- Used where area matters more than latency: PC offset, effective-address and ALU-helper paths.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits processed per cycle. WIDTH must be an integer multiple of CHUNK and CHUNK >= 1; otherwise elaboration error.
- N (localparam), WIDTH/CHUNK, number of slice cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only when busy=0
- sub  in  1  0 = A+B, 1 = A-B; latched with start
- op_a  in  WIDTH  operand A; latched with start
- op_b  in  WIDTH  operand B; latched with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  sum/difference, held until next accepted start
- carry_out  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  signed (two's-complement) overflow
- zero  out  1  result == 0

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0. State=IDLE, slice counter=0, internal carry=0.
- States: IDLE, RUN.
- IDLE: on start=1 at edge k:
  - latch op_a, and op_b XOR {WIDTH{sub}};
  - carry register = sub; slice counter = 0;
  - busy=1, done=0; go to RUN.
- RUN: each edge computes one CHUNK slice:
  - slice sum = A_slice + B'_slice + carry;
  - write the sum into result bits [i*CHUNK +: CHUNK] of the working register;
  - update carry; increment the counter.
- Last slice (counter == N-1), at edge k+N:
  - result, carry_out, overflow and zero update together;
  - done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is visible in the cycle after edge k+N, i.e. N cycles after the start edge. For N=1, done follows the start edge by one cycle.
- Output stability: result and the flags never show partial sums. The working register is internal; outputs update only at completion.
- overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the post-inversion operand.
- zero is computed on the final (post-saturation, if enabled) result.
- start while busy=1: ignored; no queuing, operands not re-latched.
- Back-to-back: start in the cycle done=1 is accepted (state is IDLE). The new op begins and done drops next cycle.
- Operand changes on op_a/op_b/sub after the start edge have no effect.
- rst mid-operation:
  - immediate return to IDLE, all outputs cleared, no done pulse;
  - the aborted op is lost and no partial result is exposed.
- Arithmetic wraps modulo 2^WIDTH (unless saturation is enabled).

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: on signed overflow, result clamps to the signed max 0x7FF..F (positive overflow) or the signed min 0x800..0 (negative overflow).
  - overflow is still reported as 1.
  - carry_out is the raw carry.
  - zero reflects the clamped value.
- Not defined: result is the wrapped two's-complement sum; no clamp logic is synthesised.

Test Plan:
- WIDTH=16, CHUNK=4: start with op_a=0x1234, op_b=0x0001, sub=0 -> done 4 cycles after the start edge; result=0x1235, carry_out=0, overflow=0, zero=0; busy high for exactly 4 cycles.
- op_a=0xFFFF, op_b=0x0001, add -> result=0x0000, carry_out=1, overflow=0, zero=1.
- op_a=0x7FFF, op_b=0x0001, add -> overflow=1. Result 0x8000 without ADDSUB_SAT_EN; 0x7FFF with it.
- op_a=0x8000, op_b=0x0001, sub -> overflow=1, carry_out=1. Result 0x7FFF without ADDSUB_SAT_EN; 0x8000 with it.
- Handshake sequence:
  - start (0x0010 + 0x0020);
  - pulse start with 0xAAAA + 0x1111 two cycles later (ignored, result 0x0030);
  - start 0x0005 - 0x0005 in the done cycle -> second done 4 cycles later, result=0x0000, zero=1, carry_out=1.
- Start 0x1234 + 0x1111, assert rst asynchronously after 2 slice cycles -> all outputs 0 immediately, no done pulse. A fresh start afterwards completes normally with 0x2345.

Source files
------------

// File: rtl/serial_addsub_unit.sv
// Multi-cycle adder/subtractor: WIDTH bits processed CHUNK bits per clock, LSB slice first.
// Optional macro ADDSUB_SAT_EN clamps the result to signed max/min on signed overflow.
module serial_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_addsub_unit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic              accept, last;
    logic [WIDTH-1:0]  a_reg, b_reg, work;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [CHUNK-1:0]  a_slice, b_slice;
    logic [CHUNK:0]    slice_sum;
    logic [WIDTH-1:0]  full_sum, final_res;
    logic              ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The final slice is merged combinationally so outputs load the complete sum in one edge
    always_comb begin
        a_slice   = a_reg[cnt*CHUNK +: CHUNK];
        b_slice   = b_reg[cnt*CHUNK +: CHUNK];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
        full_sum  = work;
        full_sum[cnt*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        ovf       = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (full_sum[WIDTH-1] != a_reg[WIDTH-1]);
        final_res = full_sum;
`ifdef ADDSUB_SAT_EN
        if (ovf) begin
            final_res = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            work      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg <= op_a;
                b_reg <= op_b ^ {WIDTH{sub}};
                carry <= sub;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                work  <= full_sum;
                carry <= slice_sum[CHUNK];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    cnt       <= '0;
                    result    <= final_res;
                    carry_out <= slice_sum[CHUNK];
                    overflow  <= ovf;
                    zero      <= (final_res == '0);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=16, CHUNK=4); honours ADDSUB_SAT_EN.
module tb_serial_addsub_unit;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
    localparam int NVEC  = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a, op_b;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             carry_out, overflow, zero;

    serial_addsub_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic s,
                                input logic [15:0] res, input logic c, input logic v, input logic z);
        vec_t e;
        e.a = a; e.b = b; e.s = s; e.res = res; e.c = c; e.v = v; e.z = z;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called just after a falling edge: start is sampled on the next rising edge.
    task automatic issue(input vec_t e, input bit scramble);
        op_a  = e.a;
        op_b  = e.b;
        sub   = e.s;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
        if (scramble) begin
            op_a = ~e.a;
            op_b = e.a ^ 16'h5A5A;
            sub  = ~e.s;
        end
    endtask

    task automatic wait_done(input int exp_lat, input string tag);
        int   lat  = 0;
        int   gaps = 0;
        bit   seen = 0;
        vec_t e;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat  = i;
            end else if (!busy) begin
                gaps++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, "_busy_gap"}, 32'(gaps), 32'd0);
            chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_done actual=done required=empty_scoreboard", tag);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_result"}, 32'(result), 32'(e.res));
                chk({tag, "_carry"}, 32'(carry_out), 32'(e.c));
                chk({tag, "_overflow"}, 32'(overflow), 32'(e.v));
                chk({tag, "_zero"}, 32'(zero), 32'(e.z));
            end
        end
    endtask

    initial begin
        int   dn;
        vec_t e;

        vecs[0]  = mk(16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        vecs[5]  = mk(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        vecs[2]  = mk(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
        vecs[2]  = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        vecs[9]  = mk(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
`endif

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i], 1'b1);
            wait_done(N, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_result_held", i), 32'(result), 32'(vecs[i].res));
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(mk(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0), 1'b0);
        @(negedge clk);
        op_a  = 16'hAAAA;
        op_b  = 16'h1111;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hs_busy_ignored_start", 32'(busy), 32'd1);
        wait_done(N - 2, "hs1");
        issue(mk(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1), 1'b0);
        wait_done(N, "hs2");

        // Asynchronous reset after two slices aborts the operation.
        @(negedge clk);
        issue(mk(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_carry", 32'(carry_out), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        issue(mk(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0), 1'b0);
        wait_done(N, "post_rst");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
